// File: rtl/decode_pkg.sv
// Shared Decode-datapath definitions: arbiter FSM states and the 3-way
// round-robin pick used by binary_mux_3_rr_ctrl.
package decode_pkg;

    localparam int unsigned NUM_REQ = 3;
    localparam int unsigned SEL_W   = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    // First set request scanning ptr+1, ptr+2, ptr (mod 3); the last served
    // source therefore has the lowest priority. Result is don't-care if req==0.
    function automatic logic [SEL_W-1:0] rr_pick3(input logic [NUM_REQ-1:0] req,
                                                  input logic [SEL_W-1:0]   ptr);
        logic [SEL_W-1:0] pick;
        case (ptr)
            2'd0:    pick = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
            2'd1:    pick = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
            default: pick = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
        endcase
        return pick;
    endfunction

endpackage

// File: rtl/binary_mux_3_case.sv
// k-bit 3:1 mux with a binary select.
//   a0, a1, a2 : data inputs
//   sb         : select (0,1,2); 3 yields zero
//   y_c        : selected data (combinational)
module binary_mux_3_case #(
    parameter int unsigned k = 1
) (
    input  logic [k-1:0] a0,
    input  logic [k-1:0] a1,
    input  logic [k-1:0] a2,
    input  logic [1:0]   sb,
    output logic [k-1:0] y_c
);

    always_comb begin
        y_c = '0;
        case (sb)
            2'd0:    y_c = a0;
            2'd1:    y_c = a1;
            2'd2:    y_c = a2;
            default: y_c = '0;
        endcase
    end

endmodule

// File: rtl/binary_mux_3_rr_ctrl.sv
// Round-robin arbiter/sequencer sharing one 3:1 mux among three packet
// sources. A grant is held for a whole packet (or until the granted source
// stays idle for TIMEOUT cycles) and the muxed beat lands in a registered
// valid/ready output stage.
//   clk, rst          : clock, async active-high reset
//   a0..a2            : requester data
//   a_vld/a_last      : per-requester beat valid / end-of-packet
//   a_rdy             : per-requester accept (one-hot or zero)
//   b/b_vld/b_last    : registered output beat
//   b_rdy             : downstream accept
//   sb                : mux select of the current grant
//   busy              : a grant is held
module binary_mux_3_rr_ctrl
    import decode_pkg::*;
#(
    parameter int unsigned k       = 1,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [k-1:0] a0,
    input  logic [k-1:0] a1,
    input  logic [k-1:0] a2,
    input  logic [2:0]   a_vld,
    input  logic [2:0]   a_last,
    output logic [2:0]   a_rdy,
    output logic [k-1:0] b,
    output logic         b_vld,
    output logic         b_last,
    input  logic         b_rdy,
    output logic [1:0]   sb,
    output logic         busy
);

    localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_e           state_q, state_d;
    logic [1:0]       sb_q, sb_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
    logic [k-1:0]     b_q, b_d;
    logic             b_vld_q, b_vld_d;
    logic             b_last_q, b_last_d;

    logic [k-1:0]     mux_c;
    logic [2:0]       sel_oh_c;
    logic [2:0]       a_rdy_c;
    logic             out_free_c;
    logic             vld_sel_c;
    logic             last_sel_c;
    logic             accept_c;

    binary_mux_3_case #(.k(k)) u_mux (
        .a0  (a0),
        .a1  (a1),
        .a2  (a2),
        .sb  (sb_q),
        .y_c (mux_c)
    );

    // State, grant, pointer, timeout counter and output stage registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            sb_q       <= 2'd0;
            ptr_q      <= 2'd2;
            idle_cnt_q <= '0;
            b_q        <= '0;
            b_vld_q    <= 1'b0;
            b_last_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            sb_q       <= sb_d;
            ptr_q      <= ptr_d;
            idle_cnt_q <= idle_cnt_d;
            b_q        <= b_d;
            b_vld_q    <= b_vld_d;
            b_last_q   <= b_last_d;
        end
    end

    // Arbitration, grant lock, timeout release and output-stage update
    always_comb begin
        state_d    = state_q;
        sb_d       = sb_q;
        ptr_d      = ptr_q;
        idle_cnt_d = idle_cnt_q;
        b_d        = b_q;
        b_vld_d    = b_vld_q;
        b_last_d   = b_last_q;
        a_rdy_c    = 3'b000;
        accept_c   = 1'b0;

        // Output register can take a beat if empty or draining this cycle
        out_free_c = !b_vld_q || b_rdy;
        sel_oh_c   = 3'b001 << sb_q;
        vld_sel_c  = |(a_vld & sel_oh_c);
        last_sel_c = |(a_last & sel_oh_c);

        case (state_q)
            ST_IDLE: begin
                idle_cnt_d = '0;
                if (|a_vld) begin
                    sb_d    = rr_pick3(a_vld, ptr_q);
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                a_rdy_c  = out_free_c ? sel_oh_c : 3'b000;
                accept_c = vld_sel_c && out_free_c;

                if (vld_sel_c) begin
                    idle_cnt_d = '0;
                end else if (TIMEOUT != 0) begin
                    if (idle_cnt_q == CNT_LAST) begin
                        state_d    = ST_IDLE;
                        ptr_d      = sb_q;
                        idle_cnt_d = '0;
                    end else begin
                        idle_cnt_d = idle_cnt_q + CNT_W'(1);
                    end
                end

                if (accept_c && last_sel_c) begin
                    state_d = ST_IDLE;
                    ptr_d   = sb_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A new beat wins over a drain so full throughput is kept
        if (accept_c) begin
            b_d      = mux_c;
            b_last_d = last_sel_c;
            b_vld_d  = 1'b1;
        end else if (b_vld_q && b_rdy) begin
            b_vld_d  = 1'b0;
        end
    end

    assign a_rdy  = a_rdy_c;
    assign b      = b_q;
    assign b_vld  = b_vld_q;
    assign b_last = b_last_q;
    assign sb     = sb_q;
    assign busy   = (state_q == ST_GRANT);

endmodule

// File: tb/tb_binary_mux_3_rr_ctrl.sv
// Self-checking bench for binary_mux_3_rr_ctrl (k=8, TIMEOUT=4): directed
// reset/contention/lock/backpressure/timeout steps, then a random run,
// all checked cycle by cycle against an integer reference model.
module tb_binary_mux_3_rr_ctrl;

    localparam int unsigned K  = 8;
    localparam int unsigned TO = 4;

    typedef struct packed {
        logic [K-1:0] d;
        logic         l;
    } beat_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [K-1:0] a0, a1, a2;
    logic [2:0]   a_vld, a_last, a_rdy;
    logic [K-1:0] b;
    logic         b_vld, b_last, b_rdy;
    logic [1:0]   sb;
    logic         busy;

    binary_mux_3_rr_ctrl #(.k(K), .TIMEOUT(TO)) dut (
        .clk    (clk),
        .rst    (rst),
        .a0     (a0),
        .a1     (a1),
        .a2     (a2),
        .a_vld  (a_vld),
        .a_last (a_last),
        .a_rdy  (a_rdy),
        .b      (b),
        .b_vld  (b_vld),
        .b_last (b_last),
        .b_rdy  (b_rdy),
        .sb     (sb),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    beat_t        src_q[3][$];
    int           gap[3];
    beat_t        acc_q[$];
    logic [K-1:0] dv[3];
    int           cyc;
    bit           rnd_mode;
    int           stall_lo, stall_hi;
    logic [K-1:0] log_d[$];
    int           log_cyc[$];
    int           grant_log[$];
    int           busy_hist[$];
    logic [K-1:0] b_hist[$];
    logic [2:0]   rdy_hist[$];
    bit           prev_busy;
    int           n_drain;

    // Reference model: granted flag, granted source, last served, idle run, output reg
    int           m_busy, m_sb, m_ptr, m_idle;
    logic         m_bv, m_bl;
    logic [K-1:0] m_b;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < 3; i++) begin
            if (src_q[i].size() != 0 && gap[i] == 0) begin
                a_vld[i]  = 1'b1;
                dv[i]     = src_q[i][0].d;
                a_last[i] = src_q[i][0].l;
            end else begin
                a_vld[i]  = 1'b0;
                dv[i]     = '0;
                a_last[i] = 1'b0;
            end
        end
        a0 = dv[0];
        a1 = dv[1];
        a2 = dv[2];
        if (rnd_mode) b_rdy = ($urandom_range(3) != 0);
        else          b_rdy = !(cyc >= stall_lo && cyc < stall_hi);
    endtask

    task automatic cycle();
        logic [2:0]   e_rdy;
        int           n_busy, n_sb, n_ptr, n_idle;
        logic         n_bv, n_bl, acc;
        logic [K-1:0] n_b;
        bit           found;
        beat_t        bt;
        int           len;

        drive_inputs();
        @(negedge clk);

        e_rdy = 3'b000;
        if (m_busy != 0 && (!m_bv || b_rdy)) e_rdy[m_sb] = 1'b1;
        chk("a_rdy", 32'(a_rdy), 32'(e_rdy));
        chk("busy", 32'(busy), 32'(m_busy));
        chk("sb", 32'(sb), 32'(m_sb));
        chk("b_vld", 32'(b_vld), 32'(m_bv));
        if (m_bv) begin
            chk("b", 32'(b), 32'(m_b));
            chk("b_last", 32'(b_last), 32'(m_bl));
        end

        if (busy && !prev_busy) grant_log.push_back(int'(sb));
        prev_busy = busy;
        busy_hist.push_back(int'(busy));
        b_hist.push_back(b);
        rdy_hist.push_back(a_rdy);

        if (b_vld && b_rdy) begin
            log_d.push_back(b);
            log_cyc.push_back(cyc);
            n_drain++;
            if (acc_q.size() == 0) begin
                chk("sb_underflow", 32'(acc_q.size()), 32'd1);
            end else begin
                chk("sb_data", 32'(b), 32'(acc_q[0].d));
                chk("sb_last", 32'(b_last), 32'(acc_q[0].l));
                void'(acc_q.pop_front());
            end
        end

        // Model next state
        n_busy = m_busy; n_sb = m_sb; n_ptr = m_ptr; n_idle = m_idle;
        n_bv = m_bv; n_bl = m_bl; n_b = m_b;
        acc = 1'b0;
        if (m_busy == 0) begin
            n_idle = 0;
            found  = 1'b0;
            for (int j = 1; j <= 3; j++) begin
                if (!found && a_vld[(m_ptr + j) % 3]) begin
                    found  = 1'b1;
                    n_sb   = (m_ptr + j) % 3;
                    n_busy = 1;
                end
            end
        end else begin
            acc = a_vld[m_sb] && (!m_bv || b_rdy);
            if (a_vld[m_sb]) n_idle = 0;
            else if (m_idle == int'(TO) - 1) begin
                n_busy = 0; n_ptr = m_sb; n_idle = 0;
            end else n_idle = m_idle + 1;
            if (acc && a_last[m_sb]) begin
                n_busy = 0; n_ptr = m_sb;
            end
        end
        if (acc) begin
            n_bv = 1'b1; n_b = dv[m_sb]; n_bl = a_last[m_sb];
        end else if (m_bv && b_rdy) begin
            n_bv = 1'b0;
        end

        // Sources: gaps, handshakes observed at the DUT, random refill
        for (int i = 0; i < 3; i++) begin
            if (gap[i] > 0) gap[i]--;
            if (a_vld[i] && a_rdy[i]) begin
                chk("no_interleave", 32'(i), 32'(m_sb));
                acc_q.push_back(src_q[i][0]);
                void'(src_q[i].pop_front());
                if (rnd_mode && $urandom_range(3) == 0) gap[i] = 1 + int'($urandom_range(5));
            end
            if (rnd_mode && src_q[i].size() == 0 && $urandom_range(2) == 0) begin
                len = 1 + int'($urandom_range(4));
                for (int n = 0; n < len; n++) begin
                    bt.d = K'($urandom);
                    bt.l = (n == len - 1);
                    src_q[i].push_back(bt);
                end
            end
        end

        @(posedge clk);
        #1;
        m_busy = n_busy; m_sb = n_sb; m_ptr = n_ptr; m_idle = n_idle;
        m_bv = n_bv; m_bl = n_bl; m_b = n_b;
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic push_beat(input int s, input logic [K-1:0] d, input logic l);
        beat_t bt;
        bt.d = d;
        bt.l = l;
        src_q[s].push_back(bt);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_b_vld", 32'(b_vld), 32'd0);
        chk("rst_a_rdy", 32'(a_rdy), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_sb", 32'(sb), 32'd0);
        chk("rst_b", 32'(b), 32'd0);
        chk("rst_b_last", 32'(b_last), 32'd0);
        for (int i = 0; i < 3; i++) begin
            src_q[i].delete();
            gap[i] = 0;
        end
        acc_q.delete(); log_d.delete(); log_cyc.delete(); grant_log.delete();
        busy_hist.delete(); b_hist.delete(); rdy_hist.delete();
        a_vld = '0; a_last = '0; a0 = '0; a1 = '0; a2 = '0; b_rdy = 1'b1;
        m_busy = 0; m_sb = 0; m_ptr = 2; m_idle = 0; m_bv = 1'b0; m_bl = 1'b0; m_b = '0;
        prev_busy = 1'b0; cyc = 0; rnd_mode = 1'b0; stall_lo = 0; stall_hi = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "simulation watchdog expired");
    end

    initial begin
        n_drain = 0;
        #1;
        do_reset();

        // Reset mid-packet with a stalled beat in the output register
        push_beat(0, 8'h11, 1'b0);
        push_beat(0, 8'h12, 1'b0);
        push_beat(0, 8'h13, 1'b1);
        stall_lo = 0; stall_hi = 1 << 20;
        run(3);
        #2;
        chk("t1_pre_b_vld", 32'(b_vld), 32'd1);
        chk("t1_pre_busy", 32'(busy), 32'd1);
        do_reset();

        // Contention, single-beat packets: order 0,1,2,0 every 2 cycles
        for (int s = 0; s < 3; s++)
            for (int n = 0; n < 3; n++)
                push_beat(s, K'(s * 16 + n), 1'b1);
        run(9);
        chk("t2_ngrant", 32'(grant_log.size() >= 4), 32'd1);
        if (grant_log.size() >= 4) begin
            chk("t2_g0", 32'(grant_log[0]), 32'd0);
            chk("t2_g1", 32'(grant_log[1]), 32'd1);
            chk("t2_g2", 32'(grant_log[2]), 32'd2);
            chk("t2_g3", 32'(grant_log[3]), 32'd0);
        end
        chk("t2_nbeat", 32'(log_d.size() >= 4), 32'd1);
        if (log_d.size() >= 4) begin
            chk("t2_d0", 32'(log_d[0]), 32'h00);
            chk("t2_d1", 32'(log_d[1]), 32'h10);
            chk("t2_d2", 32'(log_d[2]), 32'h20);
            chk("t2_d3", 32'(log_d[3]), 32'h01);
            for (int i = 1; i < 4; i++) chk("t2_spacing", 32'(log_cyc[i] - log_cyc[i-1]), 32'd2);
        end
        do_reset();

        // Packet lock: src0 arrives mid-packet of src1
        push_beat(1, 8'hA1, 1'b0);
        push_beat(1, 8'hA2, 1'b0);
        push_beat(1, 8'hA3, 1'b0);
        push_beat(1, 8'hA4, 1'b1);
        run(2);
        push_beat(0, 8'hB0, 1'b1);
        run(8);
        chk("t3_nbeat", 32'(log_d.size()), 32'd5);
        chk("t3_ngrant", 32'(grant_log.size()), 32'd2);
        if (log_d.size() == 5 && grant_log.size() == 2) begin
            chk("t3_d0", 32'(log_d[0]), 32'hA1);
            chk("t3_d3", 32'(log_d[3]), 32'hA4);
            chk("t3_d4", 32'(log_d[4]), 32'hB0);
            for (int i = 1; i < 4; i++) chk("t3_b2b", 32'(log_cyc[i] - log_cyc[i-1]), 32'd1);
            chk("t3_g0", 32'(grant_log[0]), 32'd1);
            chk("t3_g1", 32'(grant_log[1]), 32'd0);
        end
        do_reset();

        // Backpressure: b_rdy low for cycles 3..5 mid-packet
        push_beat(2, 8'hC1, 1'b0);
        push_beat(2, 8'hC2, 1'b0);
        push_beat(2, 8'hC3, 1'b0);
        push_beat(2, 8'hC4, 1'b1);
        stall_lo = 3; stall_hi = 6;
        run(10);
        for (int i = 3; i < 6; i++) begin
            chk("t4_b_hold", 32'(b_hist[i]), 32'hC2);
            chk("t4_rdy_low", 32'(rdy_hist[i]), 32'd0);
        end
        chk("t4_nbeat", 32'(log_d.size()), 32'd4);
        if (log_d.size() == 4) begin
            chk("t4_d0", 32'(log_d[0]), 32'hC1);
            chk("t4_d1", 32'(log_d[1]), 32'hC2);
            chk("t4_d2", 32'(log_d[2]), 32'hC3);
            chk("t4_d3", 32'(log_d[3]), 32'hC4);
        end
        do_reset();

        // Timeout: src2 stalls mid-packet, src0 pending takes over
        push_beat(2, 8'h55, 1'b0);
        run(2);
        push_beat(0, 8'h66, 1'b1);
        run(8);
        chk("t5_busy_c5", 32'(busy_hist[5]), 32'd1);
        chk("t5_busy_c6", 32'(busy_hist[6]), 32'd0);
        chk("t5_busy_c7", 32'(busy_hist[7]), 32'd1);
        chk("t5_ngrant", 32'(grant_log.size()), 32'd2);
        if (grant_log.size() == 2) begin
            chk("t5_g0", 32'(grant_log[0]), 32'd2);
            chk("t5_g1", 32'(grant_log[1]), 32'd0);
        end
        chk("t5_nbeat", 32'(log_d.size()), 32'd2);
        if (log_d.size() == 2) begin
            chk("t5_d0", 32'(log_d[0]), 32'h55);
            chk("t5_d1", 32'(log_d[1]), 32'h66);
        end
        do_reset();

        // Random traffic, gaps and backpressure
        n_drain = 0;
        rnd_mode = 1'b1;
        for (int g = 0; g < 60000 && n_drain < 10000; g++) cycle();
        chk("t6_beats", 32'(n_drain >= 10000), 32'd1);
        rnd_mode = 1'b0;
        for (int i = 0; i < 3; i++) gap[i] = 0;
        for (int g = 0; g < 2000; g++) begin
            if (src_q[0].size() == 0 && src_q[1].size() == 0 && src_q[2].size() == 0
                && acc_q.size() == 0 && !b_vld) break;
            cycle();
        end
        chk("t6_drained", 32'(acc_q.size()), 32'd0);
        chk("t6_src_empty", 32'(src_q[0].size() + src_q[1].size() + src_q[2].size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
